ed25519_mul_ctrl: RTL and testbench

- Host-facing sequencer for the Ed25519 scalar-multiply core wrapper.
- Holds the 256-bit scalar K (8x32) and serves it to the core's k_addr/k_din read port.
- Pulses the core enable, waits for completion and captures the core's QY write stream (8x32) into a result buffer.
- Exposes control, status, a cycle counter and an interrupt to a simple register bus.

---
 rtl/ed25519_ctrl_pkg.sv | 25 ++
 rtl/ed25519_word_buf.sv | 31 +++
 rtl/ed25519_mul_ctrl.sv | 155 +++++++++++++++
 tb/tb_ed25519_mul_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_ctrl_pkg.sv
// rtl/ed25519_ctrl_pkg.sv - shared register map, status bits and FSM states for the Ed25519 multiply sequencer
package ed25519_ctrl_pkg;

  localparam logic [4:0] ADDR_K0     = 5'h00;
  localparam logic [4:0] ADDR_QY0    = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h11;
  localparam logic [4:0] ADDR_CYCLES = 5'h12;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ERR     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/ed25519_word_buf.sv
// rtl/ed25519_word_buf.sv - 8x32 register file, one write port, two asynchronous read ports
module ed25519_word_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [2:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] mem [8];

  // clr empties the whole buffer in one cycle and beats a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/ed25519_mul_ctrl.sv
// rtl/ed25519_mul_ctrl.sv - host sequencer: scalar store, core start/complete handshake, result capture, registers
module ed25519_mul_ctrl
  import ed25519_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 24,
  parameter bit IRQ_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_wr,
  input  logic        h_rd,
  input  logic [4:0]  h_addr,
  input  logic [31:0] h_wdata,
  output logic [31:0] h_rdata,
  output logic        h_rvalid,
  output logic        irq,
  output logic        core_ena,
  input  logic        core_rdy,
  input  logic [2:0]  core_k_addr,
  output logic [31:0] core_k_din,
  input  logic [2:0]  core_qy_addr,
  input  logic        core_qy_wren,
  input  logic [31:0] core_qy_dout
);

  // cnt advances on the give-up cycle too, so it settles at all-ones on timeout
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);

  state_t state, state_n;

  logic                 busy, done, timeout, err, irq_en, rdy_q;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 wr_k, wr_ctrl, wr_status, start_req, start_ok;
  logic                 rdy_rise, cnt_last, set_done, set_timeout, set_err;
  logic                 k_we, qy_we;
  logic [3:0]           w1c;
  logic [31:0]          k_host, qy_host, qy_unused, rd_mux;

  assign wr_k      = h_wr && (h_addr[4:3] == ADDR_K0[4:3]);
  assign wr_ctrl   = h_wr && (h_addr == ADDR_CTRL);
  assign wr_status = h_wr && (h_addr == ADDR_STATUS);
  assign start_req = wr_ctrl && h_wdata[CTRL_START];
  assign start_ok  = start_req && (state == S_IDLE);
  assign set_err   = busy && (wr_k || start_req);
  assign w1c       = wr_status ? h_wdata[3:0] : 4'b0000;
  assign rdy_rise  = core_rdy && !rdy_q;
  assign cnt_last  = (cnt == CNT_LAST);
  assign k_we      = wr_k && !busy;
  assign qy_we     = busy && core_qy_wren;

  ed25519_word_buf u_k_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .we      (k_we),
    .waddr   (h_addr[2:0]),
    .wdata   (h_wdata),
    .raddr_a (h_addr[2:0]),
    .rdata_a (k_host),
    .raddr_b (core_k_addr),
    .rdata_b (core_k_din)
  );

  ed25519_word_buf u_qy_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .we      (qy_we),
    .waddr   (core_qy_addr),
    .wdata   (core_qy_dout),
    .raddr_a (h_addr[2:0]),
    .rdata_a (qy_host),
    .raddr_b (core_qy_addr),
    .rdata_b (qy_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_ok) state_n = S_FIRE;
      S_FIRE:  state_n = S_WAIT;
      S_WAIT:  if (rdy_rise || cnt_last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    core_ena    = (state == S_FIRE);
    set_done    = (state == S_DONE);
    set_timeout = (state == S_WAIT) && !rdy_rise && cnt_last;
  end

  // hardware set of done/timeout wins over a same-cycle host clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
      irq_en  <= IRQ_DEFAULT;
      rdy_q   <= 1'b0;
      cnt     <= '0;
      irq     <= 1'b0;
    end else begin
      if (start_ok)      busy <= 1'b1;
      else if (set_done) busy <= 1'b0;
      done    <= set_done    | (done    & ~w1c[ST_DONE]    & ~start_ok);
      timeout <= set_timeout | (timeout & ~w1c[ST_TIMEOUT] & ~start_ok);
      err     <= set_err     | (err     & ~w1c[ST_ERR]);
      if (wr_ctrl) irq_en <= h_wdata[CTRL_IRQ_EN];
      rdy_q <= (state == S_FIRE) ? 1'b0 : core_rdy;
      if (start_ok)              cnt <= '0;
      else if (state == S_WAIT)  cnt <= cnt + TIMEOUT_W'(1);
      irq <= done & irq_en;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (h_addr[4:3] == ADDR_K0[4:3]) begin
      rd_mux = k_host;
    end else if (h_addr[4:3] == ADDR_QY0[4:3]) begin
      rd_mux = qy_host;
    end else begin
      case (h_addr)
        ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
        ADDR_STATUS: begin
          rd_mux[ST_BUSY]    = busy;
          rd_mux[ST_DONE]    = done;
          rd_mux[ST_TIMEOUT] = timeout;
          rd_mux[ST_ERR]     = err;
        end
        ADDR_CYCLES: rd_mux = 32'(cnt);
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
    end else begin
      h_rvalid <= h_rd;
      h_rdata  <= h_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_ed25519_mul_ctrl.sv
// tb/tb_ed25519_mul_ctrl.sv - directed self-checking bench for ed25519_mul_ctrl
module tb_ed25519_mul_ctrl;

  localparam logic [4:0] A_K0     = 5'h00;
  localparam logic [4:0] A_QY0    = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h11;
  localparam logic [4:0] A_CYCLES = 5'h12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_wr = 1'b0, h_rd = 1'b0;
  logic [4:0]  h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic [31:0] h_rdata;
  logic        h_rvalid, irq, core_ena;
  logic        core_rdy = 1'b0;
  logic [2:0]  core_k_addr = '0;
  logic [31:0] core_k_din;
  logic [2:0]  core_qy_addr = '0;
  logic        core_qy_wren = 1'b0;
  logic [31:0] core_qy_dout = '0;

  int total = 0, bad = 0, ncyc = 0, ena_cnt = 0;

  ed25519_mul_ctrl #(.TIMEOUT_W(8), .IRQ_DEFAULT(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_wr         (h_wr),
    .h_rd         (h_rd),
    .h_addr       (h_addr),
    .h_wdata      (h_wdata),
    .h_rdata      (h_rdata),
    .h_rvalid     (h_rvalid),
    .irq          (irq),
    .core_ena     (core_ena),
    .core_rdy     (core_rdy),
    .core_k_addr  (core_k_addr),
    .core_k_din   (core_k_din),
    .core_qy_addr (core_qy_addr),
    .core_qy_wren (core_qy_wren),
    .core_qy_dout (core_qy_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_ena) ena_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [31:0] d);
    h_wr = 1'b1; h_addr = a; h_wdata = d;
    tick();
    h_wr = 1'b0;
  endtask

  task automatic host_rd(input logic [4:0] a, output logic [31:0] d);
    h_rd = 1'b1; h_addr = a;
    tick();
    h_rd = 1'b0;
    check("rvalid", 32'(h_rvalid), 32'd1);
    d = h_rdata;
  endtask

  // Core model: rdy rises 100 cycles after core_ena; QY[0..6] written early, QY[7] on the completion cycle.
  task automatic run_job(input logic irq_bit, input logic collide);
    int e0;
    logic [31:0] d;
    core_rdy = 1'b0;
    e0 = ena_cnt;
    host_wr(A_CTRL, {30'd0, irq_bit, 1'b1});
    check("ena_on", 32'(core_ena), 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (i < 7) begin
        core_qy_wren = 1'b1; core_qy_addr = 3'(i); core_qy_dout = 32'hA000_0000 + 32'(i);
      end else begin
        core_qy_wren = 1'b0;
      end
      tick();
      if (i == 0) check("ena_off", 32'(core_ena), 32'd0);
    end
    core_rdy = 1'b1;
    core_qy_wren = 1'b1; core_qy_addr = 3'd7; core_qy_dout = 32'hA000_0007;
    h_rd = 1'b1; h_addr = A_STATUS;
    tick();
    core_qy_wren = 1'b0;
    check("busy_edge1", h_rdata, 32'h1);
    if (collide) begin h_wr = 1'b1; h_wdata = 32'h2; end
    tick();
    h_wr = 1'b0;
    check("busy_edge2", h_rdata, 32'h1);
    tick();
    h_rd = 1'b0;
    check("status_done", h_rdata, 32'h2);
    check("ena_pulses", 32'(ena_cnt - e0), 32'd1);
    // FIRE->WAIT edge, then 99 WAIT edges before rdy plus the edge that samples it
    host_rd(A_CYCLES, d); check("cycles", d, 32'd100);
    for (int i = 0; i < 8; i++) begin
      host_rd(A_QY0 + 5'(i), d); check("qy", d, 32'hA000_0000 + 32'(i));
    end
  endtask

  initial begin
    logic [31:0] d;
    int t0;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", 32'(h_rvalid), 32'd0);
    check("rst_rdata", h_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ena", 32'(core_ena), 32'd0);
    rst_n = 1'b1;
    tick();
    host_rd(A_STATUS, d); check("rst_status", d, 32'h0);
    host_rd(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
    host_rd(A_CYCLES, d); check("rst_cycles", d, 32'h0);
    host_rd(A_K0, d);     check("rst_k0", d, 32'h0);

    for (int i = 0; i < 8; i++) host_wr(A_K0 + 5'(i), 32'h1111_1111 * 32'(i) + 32'h12);
    for (int i = 0; i < 8; i++) begin
      host_rd(A_K0 + 5'(i), d); check("k_rd", d, 32'h1111_1111 * 32'(i) + 32'h12);
    end
    core_k_addr = 3'd5;
    #1 check("k_din5", core_k_din, 32'h5555_5567);
    host_wr(5'h13, 32'hFFFF_FFFF);
    host_rd(5'h13, d); check("unmapped", d, 32'h0);

    run_job(1'b0, 1'b0);
    check("irq_off", 32'(irq), 32'd0);
    core_qy_wren = 1'b1; core_qy_addr = 3'd0; core_qy_dout = 32'hFFFF_FFFF;
    tick();
    core_qy_wren = 1'b0;
    host_rd(A_QY0, d); check("qy_idle_wr", d, 32'hA000_0000);

    // Timeout run with busy-time accesses
    core_rdy = 1'b0;
    t0 = ncyc;
    host_wr(A_CTRL, 32'h1);
    host_wr(A_K0 + 5'd3, 32'hDEAD_BEEF);
    host_wr(A_CTRL, 32'h1);
    host_rd(A_STATUS, d);      check("busy_err", d, 32'h9);
    host_rd(A_QY0 + 5'd2, d);  check("qy_partial", d, 32'h0);
    host_rd(A_K0 + 5'd3, d);   check("k3_kept", d, 32'h3333_3345);
    h_rd = 1'b1; h_addr = A_STATUS;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (h_rdata[0] == 1'b0) seen = 1'b1;
    end
    h_rd = 1'b0;
    check("to_seen", 32'(seen), 32'd1);
    // start edge + FIRE edge + 255 WAIT edges + DONE edge + read edge
    check("to_latency", 32'(ncyc - t0), 32'd259);
    check("to_ena", 32'(ena_cnt), 32'd2);
    host_rd(A_STATUS, d); check("to_status", d, 32'hE);
    host_rd(A_CYCLES, d); check("to_cycles", d, 32'd255);
    host_wr(A_STATUS, 32'hE);
    host_rd(A_STATUS, d); check("w1c_all", d, 32'h0);

    host_wr(A_CTRL, 32'h2);
    run_job(1'b1, 1'b1);
    check("irq_on", 32'(irq), 32'd1);
    host_wr(A_STATUS, 32'h2);
    check("irq_lag", 32'(irq), 32'd1);
    tick();
    check("irq_clr", 32'(irq), 32'd0);

    core_rdy = 1'b0;
    host_wr(A_CTRL, 32'h3);
    repeat (5) tick();
    h_rd = 1'b1; h_addr = A_STATUS;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ena", 32'(core_ena), 32'd0);
    check("arst_rvalid", 32'(h_rvalid), 32'd0);
    check("arst_rdata", h_rdata, 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    h_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    host_rd(A_STATUS, d);      check("arst_status", d, 32'h0);
    host_rd(A_CTRL, d);        check("arst_ctrl", d, 32'h0);
    host_rd(A_CYCLES, d);      check("arst_cycles", d, 32'h0);
    host_rd(A_K0 + 5'd1, d);   check("arst_k1", d, 32'h0);
    run_job(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
